// File: rtl/urv_loader_pkg.sv
// Shared types and helpers for the IRAM boot loader: state encoding,
// command/response codes and the ACK/NAK decision.
package urv_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } loader_state_e;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_BOOT  = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  // All frame-level error conditions collapse into one response byte.
  function automatic logic [7:0] resp_sel(input logic [7:0] cmd,
                                          input logic       sum_ok,
                                          input logic       len_zero,
                                          input logic       bad_align,
                                          input logic       bad_range);
    logic [7:0] r;
    r = RSP_NAK;
    if (sum_ok) begin
      case (cmd)
        CMD_WRITE: r = (bad_align || bad_range) ? RSP_NAK : RSP_ACK;
        CMD_BOOT:  r = len_zero ? RSP_ACK : RSP_NAK;
        default:   r = RSP_NAK;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/urv_loader_timeout.sv
// Inter-byte watchdog: loadable down-counter with clear and a one-cycle
// registered expiry pulse when it runs out.
module urv_loader_timeout #(
  parameter int unsigned g_timeout = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(g_timeout + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      expire_o <= 1'b0;
    end else begin
      expire_o <= 1'b0;
      if (clear_i) begin
        cnt <= '0;
      end else if (load_i) begin
        cnt <= W'(g_timeout);
      end else if (cnt != '0) begin
        cnt      <= cnt - 1'b1;
        expire_o <= (cnt == W'(1));
      end
    end
  end

endmodule

// File: rtl/urv_iram_loader.sv
// UART byte-stream boot loader: decodes framed WRITE/BOOT commands, streams
// words into IRAM port B and holds the CPU in reset until a good BOOT.
module urv_iram_loader import urv_loader_pkg::*; #(
  parameter int unsigned g_size      = 65536,
  parameter logic [7:0]  g_sync_byte = 8'hA5,
  parameter int unsigned g_timeout   = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        en_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [3:0]  bwe_o,
  output logic [31:0] d_o,
  output logic        cpu_rst_o,
  output logic        busy_o
);

  localparam logic [32:0] WORDS = 33'(g_size / 4);

  loader_state_e state;
  logic [7:0]  cmd_q, csum_q, sum;
  logic [31:0] base_q, addr_q, word_q, word_nx;
  logic [15:0] len_q, wcnt_q, len_nx;
  logic [1:0]  bcnt_q;
  logic        acc, bad_align, bad_range, wr_ok;
  logic        tmo_clear, tmo_load, tmo_exp;

  assign acc       = rx_valid_i & rx_ready_o;
  assign sum       = csum_q + rx_data_i;
  assign len_nx    = {rx_data_i, len_q[15:8]};
  assign word_nx   = {rx_data_i, word_q[31:8]};
  assign bad_align = (base_q[1:0] != 2'b00);
  // 33-bit sum so a huge LEN near the top of the address space cannot wrap.
  assign bad_range = ({3'b000, base_q[31:2]} + {17'b0, len_q}) > WORDS;
  assign wr_ok     = (cmd_q == CMD_WRITE) && !bad_align && !bad_range;
  assign busy_o    = (state != ST_IDLE);

  assign tmo_clear = ((state == ST_IDLE) && !(acc && rx_data_i == g_sync_byte)) ||
                     (state == ST_RESP) || ((state == ST_CSUM) && acc);
  assign tmo_load  = acc && !tmo_clear;

  urv_loader_timeout #(.g_timeout(g_timeout)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmo_clear),
    .load_i   (tmo_load),
    .expire_o (tmo_exp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rx_ready_o <= 1'b1;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      en_o       <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      bwe_o      <= '0;
      d_o        <= '0;
      cpu_rst_o  <= 1'b1;
      cmd_q      <= '0;
      csum_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
    end else begin
      en_o  <= 1'b0;
      we_o  <= 1'b0;
      bwe_o <= '0;
      if (tmo_exp && state != ST_IDLE && state != ST_RESP) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (acc && rx_data_i == g_sync_byte) state <= ST_CMD;
          ST_CMD: if (acc) begin
            cmd_q  <= rx_data_i;
            csum_q <= rx_data_i;
            bcnt_q <= '0;
            wcnt_q <= '0;
            if (rx_data_i == CMD_WRITE) cpu_rst_o <= 1'b1;
            state  <= ST_ADDR;
          end
          ST_ADDR: if (acc) begin
            csum_q <= sum;
            base_q <= {rx_data_i, base_q[31:8]};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              addr_q <= {rx_data_i, base_q[31:8]};
              state  <= ST_LEN;
            end
          end
          ST_LEN: if (acc) begin
            csum_q <= sum;
            len_q  <= len_nx;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q[0]) begin
              bcnt_q <= '0;
              state  <= (len_nx == '0) ? ST_CSUM : ST_DATA;
            end
          end
          ST_DATA: if (acc) begin
            csum_q <= sum;
            word_q <= word_nx;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              // Rejected frames still drain their payload, just without writes.
              if (wr_ok) begin
                en_o   <= 1'b1;
                we_o   <= 1'b1;
                bwe_o  <= 4'hF;
                d_o    <= word_nx;
                addr_o <= addr_q;
                addr_q <= addr_q + 32'd4;
              end
              wcnt_q <= wcnt_q + 16'd1;
              if (wcnt_q + 16'd1 == len_q) state <= ST_CSUM;
            end
          end
          ST_CSUM: if (acc) begin
            csum_q     <= sum;
            tx_data_o  <= resp_sel(cmd_q, sum == 8'h00, len_q == '0, bad_align, bad_range);
            tx_valid_o <= 1'b1;
            rx_ready_o <= 1'b0;
            if (cmd_q == CMD_BOOT && len_q == '0 && sum == 8'h00) cpu_rst_o <= 1'b0;
            state      <= ST_RESP;
          end
          ST_RESP: if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            rx_ready_o <= 1'b1;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
